// File: rtl/pipe_front_if.sv
// ----------------------------------------------------------------------------
// pipe_front_if
//
// Purpose:
//   Bundles every non-clock, non-reset signal of pipe_front_regs. This covers
//   the hazard controls, the branch redirect, the fetch and decode inputs, and
//   all of the Decode- and Execute-stage outputs.
//
// Modports:
//   slave  - the pipeline register block. It receives the controls and the
//            D-stage data, and drives the F/D/E stage outputs.
//   master - the surrounding CPU: hazard unit, imem, decoder, register file
//            and Execute. It drives the controls and data, and consumes the
//            stage outputs.
//
// Configuration:
//   PIPE_PERF_CNT_EN - adds the StallCnt / FlushCnt performance counter
//                      outputs to the bundle.
//
// Parameters:
//   XLEN   - datapath and PC width
//   CTRL_W - width of the decoded control bundle carried from D to E
// ----------------------------------------------------------------------------
interface pipe_front_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 13
);

  // Hazard unit controls and redirect
  logic              StallF;
  logic              StallD;
  logic              FlushE;
  logic              PCSrcE;
  logic [XLEN-1:0]   PCTargetE;

  // Fetch and decode inputs
  logic [31:0]       InstrF;
  logic [XLEN-1:0]   RD1D;
  logic [XLEN-1:0]   RD2D;
  logic [XLEN-1:0]   ImmExtD;
  logic [CTRL_W-1:0] CtrlD;

  // Fetch / Decode stage outputs
  logic [XLEN-1:0]   PCF;
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic [4:0]        RS1D;
  logic [4:0]        RS2D;
  logic [4:0]        RdD;

  // Execute stage outputs
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [4:0]        RS1E;
  logic [4:0]        RS2E;
  logic [4:0]        RdE;
  logic [CTRL_W-1:0] CtrlE;
  logic              ValidE;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0]       StallCnt;
  logic [31:0]       FlushCnt;
`endif

  modport slave (
    input  StallF, StallD, FlushE, PCSrcE, PCTargetE,
    input  InstrF, RD1D, RD2D, ImmExtD, CtrlD,
    output PCF, InstrD, PCD, PCPlus4D, RS1D, RS2D, RdD,
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RS1E, RS2E, RdE, CtrlE, ValidE
`ifdef PIPE_PERF_CNT_EN
    ,
    output StallCnt, FlushCnt
`endif
  );

  modport master (
    output StallF, StallD, FlushE, PCSrcE, PCTargetE,
    output InstrF, RD1D, RD2D, ImmExtD, CtrlD,
    input  PCF, InstrD, PCD, PCPlus4D, RS1D, RS2D, RdD,
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RS1E, RS2E, RdE, CtrlE, ValidE
`ifdef PIPE_PERF_CNT_EN
    ,
    input  StallCnt, FlushCnt
`endif
  );

endinterface : pipe_front_if

// File: rtl/pipe_front_regs.sv
// ----------------------------------------------------------------------------
// pipe_front_regs
//
// Purpose:
//   Front-end state of the 5-stage RISC-V pipeline. It holds:
//     - the PC register (F stage),
//     - the IF/ID register (instruction, PC, PC+4),
//     - the ID/EX register (operands, immediate, PCs, register addresses,
//       control bundle and a valid bit).
//   It obeys StallF / StallD / FlushE from the hazard unit and the taken-branch
//   redirect (PCSrcE / PCTargetE) from Execute. It also exposes the D- and
//   E-stage register addresses that the hazard unit consumes.
//
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high; has priority over every other input
//   bus   - pipe_front_if.slave. Its inputs are StallF, StallD, FlushE,
//           PCSrcE, PCTargetE, InstrF, RD1D, RD2D, ImmExtD and CtrlD. Its
//           outputs are PCF, the IF/ID fields with their RS1D/RS2D/RdD
//           slices, and the ID/EX fields including ValidE.
//
// Configuration:
//   PIPE_PERF_CNT_EN - when defined, adds saturating 32-bit counters:
//                      StallCnt counts cycles with StallD=1 and PCSrcE=0;
//                      FlushCnt counts cycles with PCSrcE=1.
//
// Parameters:
//   XLEN      - datapath / PC width
//   CTRL_W    - decoded control bundle width (bit 0 = RegWrite)
//   RESET_PC  - PC loaded on reset
//   NOP_INSTR - instruction placed in IF/ID on reset or flush (addi x0,x0,0)
// ----------------------------------------------------------------------------
module pipe_front_regs #(
  parameter int              XLEN      = 32,
  parameter int              CTRL_W    = 13,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  pipe_front_if.slave bus
);

  // --------------------------------------------------------------------------
  // Stage register layouts
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } idex_t;

  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  // A flushed or reset IF/ID holds a NOP with zero PCs.
  localparam ifid_t           IFID_NOP = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_f_next;
  logic [XLEN-1:0] pc_f_plus4;
  ifid_t           ifid_q;
  ifid_t           ifid_next;
  idex_t           idex_q;
  idex_t           idex_next;

  logic            flush_d;
  logic            flush_e;

  // A taken branch discards both younger instructions (those in F and D).
  // It therefore flushes IF/ID and forces a bubble into ID/EX.
  assign flush_d = bus.PCSrcE;
  assign flush_e = bus.FlushE | bus.PCSrcE;

  // The add wraps modulo 2^XLEN by construction.
  assign pc_f_plus4 = pc_f + PC_STEP;

  always_comb begin
    // NOTE: every variable assigned in this block gets a default first. This
    // means no path can leave a value unassigned, so no latch is inferred.
    pc_f_next = pc_f;
    ifid_next = ifid_q;
    idex_next = '0;

    // PC: a redirect overrides a fetch stall.
    if (bus.PCSrcE) begin
      pc_f_next = bus.PCTargetE;
    end else if (!bus.StallF) begin
      pc_f_next = pc_f_plus4;
    end

    // IF/ID: a flush overrides a decode stall.
    if (flush_d) begin
      ifid_next = IFID_NOP;
    end else if (!bus.StallD) begin
      ifid_next = '{instr: bus.InstrF, pc: pc_f, pc_plus4: pc_f_plus4};
    end

    // ID/EX is never stalled. It either takes the D-stage values or becomes
    // an all-zero bubble. An all-zero bubble has zero controls, so it cannot
    // write the register file or memory.
    if (!flush_e) begin
      idex_next.rd1      = bus.RD1D;
      idex_next.rd2      = bus.RD2D;
      idex_next.imm      = bus.ImmExtD;
      idex_next.pc       = ifid_q.pc;
      idex_next.pc_plus4 = ifid_q.pc_plus4;
      idex_next.rs1      = ifid_q.instr[19:15];
      idex_next.rs2      = ifid_q.instr[24:20];
      idex_next.rd       = ifid_q.instr[11:7];
      idex_next.ctrl     = bus.CtrlD;
      idex_next.valid    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, whatever order the statements run in.
    if (reset) begin
      pc_f   <= RESET_PC;
      ifid_q <= IFID_NOP;
      idex_q <= '0;
    end else begin
      pc_f   <= pc_f_next;
      ifid_q <= ifid_next;
      idex_q <= idex_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.PCF      = pc_f;

  assign bus.InstrD   = ifid_q.instr;
  assign bus.PCD      = ifid_q.pc;
  assign bus.PCPlus4D = ifid_q.pc_plus4;

  // D-stage register addresses are combinational slices for the hazard unit.
  assign bus.RS1D     = ifid_q.instr[19:15];
  assign bus.RS2D     = ifid_q.instr[24:20];
  assign bus.RdD      = ifid_q.instr[11:7];

  assign bus.RD1E     = idex_q.rd1;
  assign bus.RD2E     = idex_q.rd2;
  assign bus.ImmExtE  = idex_q.imm;
  assign bus.PCE      = idex_q.pc;
  assign bus.PCPlus4E = idex_q.pc_plus4;
  assign bus.RS1E     = idex_q.rs1;
  assign bus.RS2E     = idex_q.rs2;
  assign bus.RdE      = idex_q.rd;
  assign bus.CtrlE    = idex_q.ctrl;
  assign bus.ValidE   = idex_q.valid;

`ifdef PIPE_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Performance counters. Both saturate at all-ones and never wrap.
  // A stall cycle that coincides with a redirect counts only as a flush,
  // because the redirect discards the stalled instruction.
  // --------------------------------------------------------------------------
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.StallD && !bus.PCSrcE && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bus.PCSrcE && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;
`endif

endmodule : pipe_front_regs

// File: tb/tb_pipe_front_regs.sv
// ----------------------------------------------------------------------------
// tb_pipe_front_regs
//
// Directed bench for pipe_front_regs. It covers:
//   - reset state,
//   - streaming fetch,
//   - load-use stall,
//   - taken branch,
//   - redirect during a stall,
//   - PC wrap (second instance with RESET_PC = 0xFFFF_FFFC),
//   - reset mid-stream,
//   - and, when PIPE_PERF_CNT_EN is defined, the performance counters.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the same
// point, so nothing moves near the active edge.
// ----------------------------------------------------------------------------
module tb_pipe_front_regs;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset;

  int n_cmp;
  int n_err;

  pipe_front_if #(.XLEN(32), .CTRL_W(13)) bus ();
  pipe_front_if #(.XLEN(32), .CTRL_W(13)) wbus ();

  pipe_front_regs #(
    .XLEN(32), .CTRL_W(13), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running instance whose reset PC sits just below the wrap point.
  pipe_front_regs #(
    .XLEN(32), .CTRL_W(13), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)
  ) u_dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    reset          = 1'b1;
    bus.StallF     = 1'b0;
    bus.StallD     = 1'b0;
    bus.FlushE     = 1'b0;
    bus.PCSrcE     = 1'b0;
    bus.PCTargetE  = '0;
    bus.InstrF     = NOP;
    bus.RD1D       = '0;
    bus.RD2D       = '0;
    bus.ImmExtD    = '0;
    bus.CtrlD      = '0;
    wbus.StallF    = 1'b0;
    wbus.StallD    = 1'b0;
    wbus.FlushE    = 1'b0;
    wbus.PCSrcE    = 1'b0;
    wbus.PCTargetE = '0;
    wbus.InstrF    = NOP;
    wbus.RD1D      = '0;
    wbus.RD2D      = '0;
    wbus.ImmExtD   = '0;
    wbus.CtrlD     = '0;

    // ---- Reset for two cycles ----
    tick();
    tick();
    check("rst_pcf",      bus.PCF,              32'h0);
    check("rst_instrd",   bus.InstrD,           NOP);
    check("rst_pcd",      bus.PCD,              32'h0);
    check("rst_pcp4d",    bus.PCPlus4D,         32'h0);
    check("rst_valide",   32'(bus.ValidE),      32'h0);
    check("rst_ctrle",    32'(bus.CtrlE),       32'h0);
    check("rst_rde",      32'(bus.RdE),         32'h0);
    check("rst_pce",      bus.PCE,              32'h0);
    check("wrap_rst_pcf", wbus.PCF,             32'hFFFF_FFFC);

    // ---- Release reset: instruction at PC 0 ----
    reset      = 1'b0;
    bus.InstrF = 32'h00A0_0093;              // addi x1,x0,10
    check("s0_pcf",   bus.PCF,    32'h0);
    check("s0_instrd", bus.InstrD, NOP);
    tick();
    check("s1_pcf",      bus.PCF,         32'h4);
    check("s1_instrd",   bus.InstrD,      32'h00A0_0093);
    check("s1_pcd",      bus.PCD,         32'h0);
    check("s1_pcp4d",    bus.PCPlus4D,    32'h4);
    check("s1_valide",   32'(bus.ValidE), 32'h1);   // reset NOP reaches E
    check("wrap_pcf",    wbus.PCF,        32'h0);

    // Instruction at PC 4; D-stage operands go with InstrD = 0x00A00093.
    bus.InstrF  = 32'h00B0_0113;             // addi x2,x0,11
    bus.CtrlD   = 13'h0001;
    bus.RD1D    = 32'h0000_0011;
    bus.RD2D    = 32'h0000_0022;
    bus.ImmExtD = 32'h0000_000A;
    tick();
    check("s2_pcf",    bus.PCF,         32'h8);
    check("s2_instrd", bus.InstrD,      32'h00B0_0113);
    check("s2_rdd",    32'(bus.RdD),    32'h2);
    check("s2_rs2d",   32'(bus.RS2D),   32'hB);
    check("s2_rde",    32'(bus.RdE),    32'h1);
    check("s2_rs1e",   32'(bus.RS1E),   32'h0);
    check("s2_rs2e",   32'(bus.RS2E),   32'hA);
    check("s2_valide", 32'(bus.ValidE), 32'h1);
    check("s2_ctrle",  32'(bus.CtrlE),  32'h1);
    check("s2_rd1e",   bus.RD1E,        32'h11);
    check("s2_rd2e",   bus.RD2E,        32'h22);
    check("s2_imme",   bus.ImmExtE,     32'hA);
    check("s2_pce",    bus.PCE,         32'h0);
    check("s2_pcp4e",  bus.PCPlus4E,    32'h4);

    // ---- Load-use stall on add x3,x1,x2 ----
    bus.InstrF = 32'h0020_81B3;              // fetched at PC 8
    tick();
    check("lu_pcf",    bus.PCF,       32'hC);
    check("lu_instrd", bus.InstrD,    32'h0020_81B3);
    check("lu_rs1d",   32'(bus.RS1D), 32'h1);
    check("lu_rs2d",   32'(bus.RS2D), 32'h2);
    check("lu_rdd",    32'(bus.RdD),  32'h3);

    bus.StallF = 1'b1;
    bus.StallD = 1'b1;
    bus.FlushE = 1'b1;
    bus.InstrF = 32'h0031_0233;              // instruction at PC 12
    tick();
    check("lu_hold_pcf",    bus.PCF,         32'hC);
    check("lu_hold_instrd", bus.InstrD,      32'h0020_81B3);
    check("lu_bub_valide",  32'(bus.ValidE), 32'h0);
    check("lu_bub_ctrle",   32'(bus.CtrlE),  32'h0);
    check("lu_bub_rde",     32'(bus.RdE),    32'h0);
    check("lu_bub_rd1e",    bus.RD1E,        32'h0);

    bus.StallF = 1'b0;
    bus.StallD = 1'b0;
    bus.FlushE = 1'b0;
    tick();
    check("lu_rel_pcf",    bus.PCF,         32'h10);
    check("lu_rel_instrd", bus.InstrD,      32'h0031_0233);
    check("lu_rel_rs1e",   32'(bus.RS1E),   32'h1);
    check("lu_rel_rs2e",   32'(bus.RS2E),   32'h2);
    check("lu_rel_rde",    32'(bus.RdE),    32'h3);
    check("lu_rel_valide", 32'(bus.ValidE), 32'h1);
    check("lu_rel_pce",    bus.PCE,         32'h8);

    // ---- Stream forward to PC 0x20 ----
    bus.InstrF = NOP;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stream_pcf", bus.PCF, 32'h10 + 32'(4 * i));
    end

    // ---- Taken branch at PCF = 0x20 ----
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'h0000_0100;
    tick();
    check("br_pcf",    bus.PCF,         32'h100);
    check("br_instrd", bus.InstrD,      NOP);
    check("br_pcd",    bus.PCD,         32'h0);
    check("br_valide", 32'(bus.ValidE), 32'h0);
    check("br_ctrle",  32'(bus.CtrlE),  32'h0);

    bus.PCSrcE = 1'b0;
    bus.CtrlD  = 13'h0000;
    bus.InstrF = 32'h0040_0293;              // fetched at 0x100
    tick();
    check("br2_instrd", bus.InstrD,      32'h0040_0293);
    check("br2_pcd",    bus.PCD,         32'h100);
    check("br2_pcp4d",  bus.PCPlus4D,    32'h104);
    check("br2_pcf",    bus.PCF,         32'h104);
    check("br2_valide", 32'(bus.ValidE), 32'h1);

    // ---- Redirect concurrent with a fetch/decode stall ----
    bus.PCSrcE    = 1'b1;
    bus.StallF    = 1'b1;
    bus.StallD    = 1'b1;
    bus.PCTargetE = 32'h0000_0200;
    bus.CtrlD     = 13'h1FFF;
    tick();
    check("sim_pcf",    bus.PCF,         32'h200);
    check("sim_instrd", bus.InstrD,      NOP);
    check("sim_valide", 32'(bus.ValidE), 32'h0);
    check("sim_ctrle",  32'(bus.CtrlE),  32'h0);
`ifdef PIPE_PERF_CNT_EN
    check("cnt_stall_a", bus.StallCnt, 32'd1);
    check("cnt_flush_a", bus.FlushCnt, 32'd2);
`endif

    // ---- Reset mid-stream (with a redirect pending, which reset overrides) ----
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.PCTargetE = 32'h0000_0300;
    reset         = 1'b1;
    tick();
    check("mrst_pcf",    bus.PCF,         32'h0);
    check("mrst_instrd", bus.InstrD,      NOP);
    check("mrst_valide", 32'(bus.ValidE), 32'h0);
    check("mrst_ctrle",  32'(bus.CtrlE),  32'h0);
    check("mrst_pce",    bus.PCE,         32'h0);
`ifdef PIPE_PERF_CNT_EN
    check("mrst_stallcnt", bus.StallCnt, 32'd0);
    check("mrst_flushcnt", bus.FlushCnt, 32'd0);
`endif
    reset      = 1'b0;
    bus.PCSrcE = 1'b0;
    bus.CtrlD  = 13'h0000;
    tick();
    check("mrst_resume_pcf", bus.PCF, 32'h4);

`ifdef PIPE_PERF_CNT_EN
    // ---- Counters: 3 stall cycles, then 2 branch cycles ----
    bus.StallF = 1'b1;
    bus.StallD = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'h0000_0040;
    for (int i = 0; i < 2; i++) tick();
    bus.PCSrcE = 1'b0;
    tick();
    check("cnt_stall", bus.StallCnt, 32'd3);
    check("cnt_flush", bus.FlushCnt, 32'd2);
    reset = 1'b1;
    tick();
    check("cnt_rst_stall", bus.StallCnt, 32'd0);
    check("cnt_rst_flush", bus.FlushCnt, 32'd0);
    reset = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_front_regs

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Owns the PC register plus the IF/ID and ID/EX pipeline registers of the 5-stage RISC-V CPU.
- Acts on the stall/flush controls from the hazard unit (StallF, StallD, FlushE) and on taken-branch redirects from Execute.
- Produces the Decode- and Execute-stage register addresses that the hazard unit consumes.
- Sits between instruction memory/decoder and the Execute stage.

Parameters:
- XLEN, 32, datapath and PC width
- CTRL_W, 13, width of decoded control bundle carried D->E
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted into IF/ID on flush/reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID register
- FlushE  in  1  bubble ID/EX register (load-use)
- PCSrcE  in  1  taken branch/jump resolved in Execute
- PCTargetE  in  XLEN  redirect target
- InstrF  in  32  instruction read at PCF (combinational imem)
- RD1D  in  XLEN  register file read data 1
- RD2D  in  XLEN  register file read data 2
- ImmExtD  in  XLEN  extended immediate
- CtrlD  in  CTRL_W  decoded controls; bit 0 = RegWrite
- PCF  out  XLEN  fetch PC
- InstrD  out  32  Decode instruction
- PCD  out  XLEN  Decode PC
- PCPlus4D  out  XLEN  Decode PC+4
- RS1D  out  5  InstrD[19:15]
- RS2D  out  5  InstrD[24:20]
- RdD  out  5  InstrD[11:7]
- RD1E  out  XLEN  Execute operand 1
- RD2E  out  XLEN  Execute operand 2
- ImmExtE  out  XLEN  Execute immediate
- PCE  out  XLEN  Execute PC
- PCPlus4E  out  XLEN  Execute PC+4
- RS1E  out  5  Execute source register 1
- RS2E  out  5  Execute source register 2
- RdE  out  5  Execute destination register
- CtrlE  out  CTRL_W  Execute controls
- ValidE  out  1  Execute holds a real instruction (0 = bubble)

Behaviour:
- All state updates on rising clk. reset has priority over every other input.
- Reset values: PCF = RESET_PC; InstrD = NOP_INSTR; PCD, PCPlus4D = 0; all E-stage registers = 0; CtrlE = 0; ValidE = 0.
- RS1D/RS2D/RdD are combinational slices of InstrD. Everything else is registered.
- Internal flushes:
  - FlushD_int = PCSrcE.
  - FlushE_int = FlushE | PCSrcE.
- PC register:
  - next PCF = PCTargetE if PCSrcE;
  - else hold if StallF;
  - else PCF + 4.
  - PCSrcE overrides StallF. XLEN-bit add wraps modulo 2^XLEN (PCF = 0xFFFF_FFFC → 0x0000_0000).
- IF/ID register:
  - FlushD_int loads InstrD = NOP_INSTR, PCD = 0, PCPlus4D = 0;
  - else hold if StallD;
  - else load InstrF, PCF, PCF + 4.
  - Flush overrides stall.
- ID/EX register:
  - FlushE_int loads all E fields = 0, CtrlE = 0, ValidE = 0;
  - else load D-stage values (RS1E/RS2E/RdE from InstrD fields) and set ValidE = 1.
  - ID/EX is never stalled.
  - A zero CtrlE means no RegWrite/MemWrite, so a bubble is architecturally inert.
- Latency: one instruction per cycle when there is no stall or flush. InstrF reaches E-stage fields 2 cycles after PCF presents it.
- Load-use stall (StallF = StallD = FlushE = 1):
  - PCF and IF/ID hold for exactly that cycle;
  - one bubble enters E;
  - the held instruction re-enters E on the next unstalled cycle.
- Branch taken (PCSrcE = 1): the two younger instructions (in F and D) are discarded, i.e. 2 bubbles. PCF = PCTargetE on the next cycle.
- Simultaneous PCSrcE and StallD/StallF: redirect wins, and the stalled instruction is discarded.
- Reset mid-stream: reset for one cycle returns all outputs to reset values on that edge. Fetch resumes at RESET_PC the following cycle.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - adds outputs StallCnt (32) and FlushCnt (32);
  - StallCnt increments each cycle StallD = 1 and PCSrcE = 0;
  - FlushCnt increments each cycle PCSrcE = 1;
  - both clear on reset and saturate at 32'hFFFF_FFFF (no wrap).
- Not defined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset for 2 cycles, then release with InstrF streaming 0x00A00093, 0x00B00113 → PCF = 0, 4, 8 on successive cycles; InstrD = 0x00000013 on the first cycle, 0x00A00093 on the next; RdE = 1, ValidE = 1 one cycle later.
- Load-use: StallF = StallD = FlushE = 1 for one cycle while InstrD = 0x002081B3 → PCF and InstrD hold for 1 cycle; ValidE = 0 with CtrlE = 0 that cycle; next cycle RS1E = 1, RS2E = 2, RdE = 3, ValidE = 1.
- Branch: PCSrcE = 1, PCTargetE = 0x100 while PCF = 0x20 → next cycle PCF = 0x100, InstrD = NOP_INSTR, ValidE = 0; InstrD = InstrF fetched at 0x100 one cycle later.
- Simultaneous PCSrcE = 1 and StallF = StallD = 1 → PCF = PCTargetE, InstrD = NOP_INSTR, ValidE = 0.
- PC wrap: reset with RESET_PC = 0xFFFF_FFFC → PCF = 0xFFFF_FFFC, then 0x0000_0000.
- With PIPE_PERF_CNT_EN: 3 stall cycles and 2 branch cycles → StallCnt = 3, FlushCnt = 2; reset → both 0.
